operand_collector: RTL and testbench



---
 rtl/bgpu_pkg.sv | 12 +
 rtl/operand_collector.sv | 189 ++++++++++++++++++
 tb/tb_operand_collector.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bgpu_pkg.sv
// Shared BGPU types: the instruction word and the operand collector state encoding.
package bgpu_pkg;

    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } opc_state_e;

endpackage

// File: rtl/operand_collector.sv
// Single-entry operand collector: accepts one dispatched instruction, reads its
// required source registers from the register file (in-order responses), then
// hands the instruction plus operand data to the execution units.
// Optional feature macro: BGPU_OPC_BACK_TO_BACK_EN (accept a new dispatch in the
// same cycle the collected instruction is handed off).
module operand_collector
    import bgpu_pkg::*;
#(
    parameter int unsigned NumTags         = 8,
    parameter int unsigned PcWidth         = 32,
    parameter int unsigned WarpWidth       = 32,
    parameter int unsigned RegIdxWidth     = 6,
    parameter int unsigned OperandsPerInst = 2,
    parameter int unsigned RegWidth        = 32,
    localparam int unsigned TagWidth       = $clog2(NumTags),
    localparam int unsigned DataWidth      = WarpWidth * RegWidth
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,

    output logic                                         opc_ready_o,
    input  logic                                         disp_valid_i,
    input  logic [TagWidth-1:0]                          disp_tag_i,
    input  logic [PcWidth-1:0]                           disp_pc_i,
    input  logic [WarpWidth-1:0]                         disp_act_mask_i,
    input  inst_t                                        disp_inst_i,
    input  logic [RegIdxWidth-1:0]                       disp_dst_i,
    input  logic [OperandsPerInst-1:0]                   disp_operands_required_i,
    input  logic [OperandsPerInst-1:0][RegIdxWidth-1:0]  disp_operands_i,

    output logic                                         rf_req_valid_o,
    input  logic                                         rf_req_ready_i,
    output logic [RegIdxWidth-1:0]                       rf_req_reg_o,
    input  logic                                         rf_rsp_valid_i,
    input  logic [DataWidth-1:0]                         rf_rsp_data_i,

    output logic                                         eu_valid_o,
    input  logic                                         eu_ready_i,
    output logic [TagWidth-1:0]                          eu_tag_o,
    output logic [PcWidth-1:0]                           eu_pc_o,
    output logic [WarpWidth-1:0]                         eu_act_mask_o,
    output inst_t                                        eu_inst_o,
    output logic [RegIdxWidth-1:0]                       eu_dst_o,
    output logic [OperandsPerInst-1:0][DataWidth-1:0]    eu_operands_o
);

    localparam int unsigned SelWidth = (OperandsPerInst > 1) ? $clog2(OperandsPerInst) : 1;

    opc_state_e                                   state_q, state_d;
    logic [TagWidth-1:0]                          tag_q, tag_d;
    logic [PcWidth-1:0]                           pc_q, pc_d;
    logic [WarpWidth-1:0]                         mask_q, mask_d;
    inst_t                                        inst_q, inst_d;
    logic [RegIdxWidth-1:0]                       dst_q, dst_d;
    logic [OperandsPerInst-1:0]                   required_q, required_d;
    logic [OperandsPerInst-1:0]                   requested_q, requested_d;
    logic [OperandsPerInst-1:0]                   received_q, received_d;
    logic [OperandsPerInst-1:0][RegIdxWidth-1:0]  operands_q, operands_d;
    logic [OperandsPerInst-1:0][DataWidth-1:0]    data_q, data_d;

    logic                                         req_any, rsp_any, dispatch;
    logic [SelWidth-1:0]                          req_sel, rsp_sel;

    // Lowest-index priority encoders: next operand to request, next operand to receive.
    always_comb begin
        req_any = 1'b0;
        req_sel = '0;
        rsp_any = 1'b0;
        rsp_sel = '0;
        for (int unsigned i = 0; i < OperandsPerInst; i++) begin
            if (!req_any && required_q[i] && !requested_q[i]) begin
                req_any = 1'b1;
                req_sel = SelWidth'(i);
            end
            if (!rsp_any && requested_q[i] && !received_q[i]) begin
                rsp_any = 1'b1;
                rsp_sel = SelWidth'(i);
            end
        end
    end

`ifdef BGPU_OPC_BACK_TO_BACK_EN
    assign opc_ready_o = (state_q == EMPTY) || ((state_q == READY) && eu_ready_i);
`else
    assign opc_ready_o = (state_q == EMPTY);
`endif

    assign dispatch       = disp_valid_i && opc_ready_o;
    assign rf_req_valid_o = (state_q == COLLECT) && req_any;
    assign rf_req_reg_o   = rf_req_valid_o ? operands_q[req_sel] : '0;
    assign eu_valid_o     = (state_q == READY);
    assign eu_tag_o       = tag_q;
    assign eu_pc_o        = pc_q;
    assign eu_act_mask_o  = mask_q;
    assign eu_inst_o      = inst_q;
    assign eu_dst_o       = dst_q;
    assign eu_operands_o  = data_q;

    // Next-state logic: collection progress, hand-off, and loading a new dispatch.
    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        pc_d        = pc_q;
        mask_d      = mask_q;
        inst_d      = inst_q;
        dst_d       = dst_q;
        required_d  = required_q;
        requested_d = requested_q;
        received_d  = received_q;
        operands_d  = operands_q;
        data_d      = data_q;

        unique case (state_q)
            COLLECT: begin
                if (rf_req_valid_o && rf_req_ready_i) begin
                    requested_d[req_sel] = 1'b1;
                end
                if (rf_rsp_valid_i && rsp_any) begin
                    received_d[rsp_sel] = 1'b1;
                    data_d[rsp_sel]     = rf_rsp_data_i;
                end
                if ((received_d & required_q) == required_q) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (eu_ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: ;
        endcase

        // A load overrides the hand-off above when both happen in one cycle.
        if (dispatch) begin
            tag_d       = disp_tag_i;
            pc_d        = disp_pc_i;
            mask_d      = disp_act_mask_i;
            inst_d      = disp_inst_i;
            dst_d       = disp_dst_i;
            required_d  = disp_operands_required_i;
            operands_d  = disp_operands_i;
            requested_d = '0;
            received_d  = '0;
            data_d      = '0;
            state_d     = (|disp_operands_required_i) ? COLLECT : READY;
        end
    end

    // State and entry registers; reset discards any entry in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            tag_q       <= '0;
            pc_q        <= '0;
            mask_q      <= '0;
            inst_q      <= '0;
            dst_q       <= '0;
            required_q  <= '0;
            requested_q <= '0;
            received_q  <= '0;
            operands_q  <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            pc_q        <= pc_d;
            mask_q      <= mask_d;
            inst_q      <= inst_d;
            dst_q       <= dst_d;
            required_q  <= required_d;
            requested_q <= requested_d;
            received_q  <= received_d;
            operands_q  <= operands_d;
            data_q      <= data_d;
        end
    end

`ifndef SYNTHESIS
    // A register file response must always correspond to an outstanding request.
    always_ff @(posedge clk_i) begin
        if (rst_ni && rf_rsp_valid_i) begin
            assert ((state_q == COLLECT) && rsp_any)
                else $error("operand_collector: response without outstanding request");
        end
    end
`endif

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector with a small in-order register file model.
module tb_operand_collector;
    import bgpu_pkg::*;

    localparam int unsigned DW = 32 * 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  opc_ready_o;
    logic                  disp_valid_i;
    logic [2:0]            disp_tag_i;
    logic [31:0]           disp_pc_i;
    logic [31:0]           disp_act_mask_i;
    inst_t                 disp_inst_i;
    logic [5:0]            disp_dst_i;
    logic [1:0]            disp_operands_required_i;
    logic [1:0][5:0]       disp_operands_i;
    logic                  rf_req_valid_o;
    logic                  rf_req_ready_i;
    logic [5:0]            rf_req_reg_o;
    logic                  rf_rsp_valid_i;
    logic [DW-1:0]         rf_rsp_data_i;
    logic                  eu_valid_o;
    logic                  eu_ready_i;
    logic [2:0]            eu_tag_o;
    logic [31:0]           eu_pc_o;
    logic [31:0]           eu_act_mask_o;
    inst_t                 eu_inst_o;
    logic [5:0]            eu_dst_o;
    logic [1:0][DW-1:0]    eu_operands_o;

    int          ntests = 0;
    int          nfail  = 0;
    int unsigned cyc    = 0;
    int unsigned lat    = 1;
    int unsigned nreq   = 0;
    int unsigned nrsp   = 0;
    int unsigned base;

    typedef struct {
        logic [5:0]  r;
        int unsigned due;
    } rq_t;
    rq_t rq[$];

    operand_collector #(
        .NumTags(8), .PcWidth(32), .WarpWidth(32), .RegIdxWidth(6),
        .OperandsPerInst(2), .RegWidth(32)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .opc_ready_o(opc_ready_o), .disp_valid_i(disp_valid_i),
        .disp_tag_i(disp_tag_i), .disp_pc_i(disp_pc_i),
        .disp_act_mask_i(disp_act_mask_i), .disp_inst_i(disp_inst_i),
        .disp_dst_i(disp_dst_i), .disp_operands_required_i(disp_operands_required_i),
        .disp_operands_i(disp_operands_i),
        .rf_req_valid_o(rf_req_valid_o), .rf_req_ready_i(rf_req_ready_i),
        .rf_req_reg_o(rf_req_reg_o), .rf_rsp_valid_i(rf_rsp_valid_i),
        .rf_rsp_data_i(rf_rsp_data_i),
        .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i), .eu_tag_o(eu_tag_o),
        .eu_pc_o(eu_pc_o), .eu_act_mask_o(eu_act_mask_o), .eu_inst_o(eu_inst_o),
        .eu_dst_o(eu_dst_o), .eu_operands_o(eu_operands_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rfd(input logic [5:0] r);
        rfd = {32{32'hC0DE_0000 | 32'(r)}};
    endfunction

    // Register file model: in-order responses, fixed latency after the request handshake.
    always @(negedge clk) begin
        rf_rsp_valid_i = 1'b0;
        rf_rsp_data_i  = '0;
        if (!rst_n) begin
            rq.delete();
        end else begin
            if (rq.size() > 0 && rq[0].due == cyc) begin
                rf_rsp_valid_i = 1'b1;
                rf_rsp_data_i  = rfd(rq[0].r);
                rq.pop_front();
                nrsp++;
            end
            if (rf_req_valid_o && rf_req_ready_i) begin
                rq.push_back('{r: rf_req_reg_o, due: cyc + lat});
                nreq++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp)
            else begin
                nfail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        ntests++;
        assert (obs === exp)
            else begin
                nfail++;
                $error("FAIL %s: observed[63:0] %0h expected[63:0] %0h", tag, obs[63:0], exp[63:0]);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_opc_ready"}, 64'(opc_ready_o), 64'd1);
        chk({p, "_req_valid"}, 64'(rf_req_valid_o), 64'd0);
        chk({p, "_req_reg"}, 64'(rf_req_reg_o), 64'd0);
        chk({p, "_eu_valid"}, 64'(eu_valid_o), 64'd0);
        chk({p, "_eu_tag"}, 64'(eu_tag_o), 64'd0);
        chk({p, "_eu_pc"}, 64'(eu_pc_o), 64'd0);
        chk_w({p, "_op0"}, eu_operands_o[0], '0);
        chk_w({p, "_op1"}, eu_operands_o[1], '0);
    endtask

    task automatic set_disp(input logic [2:0] tag, input logic [1:0] req,
                            input logic [5:0] op0, input logic [5:0] op1);
        disp_tag_i               = tag;
        disp_pc_i                = 32'h1000 + 32'(tag);
        disp_act_mask_i          = 32'hF0F0_0000 | 32'(tag);
        disp_inst_i              = 32'hA500_0000 | 32'(tag);
        disp_dst_i               = 6'd40 + 6'(tag);
        disp_operands_required_i = req;
        disp_operands_i[0]       = op0;
        disp_operands_i[1]       = op1;
        disp_valid_i             = 1'b1;
    endtask

    task automatic handoff(input string p);
        eu_ready_i = 1'b1;
        tick();
        eu_ready_i = 1'b0;
        chk({p, "_done_valid"}, 64'(eu_valid_o), 64'd0);
        chk({p, "_done_ready"}, 64'(opc_ready_o), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        disp_valid_i = 1'b0;
        disp_tag_i = '0; disp_pc_i = '0; disp_act_mask_i = '0; disp_inst_i = '0;
        disp_dst_i = '0; disp_operands_required_i = '0; disp_operands_i = '0;
        rf_req_ready_i = 1'b1;
        eu_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        tick();

        // Two operands, regs 3 and 7, latency 1.
        set_disp(3'd1, 2'b11, 6'd3, 6'd7);
        tick();
        disp_valid_i = 1'b0;
        chk("t1_c1_req_valid", 64'(rf_req_valid_o), 64'd1);
        chk("t1_c1_req_reg", 64'(rf_req_reg_o), 64'd3);
        chk("t1_c1_opc_ready", 64'(opc_ready_o), 64'd0);
        tick();
        chk("t1_c2_req_valid", 64'(rf_req_valid_o), 64'd1);
        chk("t1_c2_req_reg", 64'(rf_req_reg_o), 64'd7);
        tick();
        chk("t1_c3_req_valid", 64'(rf_req_valid_o), 64'd0);
        chk("t1_c3_eu_valid", 64'(eu_valid_o), 64'd0);
        tick();
        chk("t1_c4_eu_valid", 64'(eu_valid_o), 64'd1);
        chk_w("t1_op0", eu_operands_o[0], rfd(6'd3));
        chk_w("t1_op1", eu_operands_o[1], rfd(6'd7));
        chk("t1_tag", 64'(eu_tag_o), 64'd1);
        chk("t1_pc", 64'(eu_pc_o), 64'h1001);
        chk("t1_mask", 64'(eu_act_mask_o), 64'hF0F0_0001);
        chk("t1_inst", 64'(eu_inst_o), 64'hA500_0001);
        chk("t1_dst", 64'(eu_dst_o), 64'd41);
        chk("t1_nreq", 64'(nreq), 64'd2);
        handoff("t1");

        // Only operand 1 required (reg 5); slot 0 stays zero.
        base = nreq;
        set_disp(3'd2, 2'b10, 6'd9, 6'd5);
        tick();
        disp_valid_i = 1'b0;
        chk("t2_req_valid", 64'(rf_req_valid_o), 64'd1);
        chk("t2_req_reg", 64'(rf_req_reg_o), 64'd5);
        tick();
        chk("t2_req_done", 64'(rf_req_valid_o), 64'd0);
        tick();
        chk("t2_eu_valid", 64'(eu_valid_o), 64'd1);
        chk_w("t2_op0", eu_operands_o[0], '0);
        chk_w("t2_op1", eu_operands_o[1], rfd(6'd5));
        chk("t2_nreq", 64'(nreq - base), 64'd1);
        chk("t2_opc_ready", 64'(opc_ready_o), 64'd0);
        handoff("t2");

        // No operands required.
        base = nreq;
        set_disp(3'd3, 2'b00, 6'd1, 6'd2);
        tick();
        disp_valid_i = 1'b0;
        chk("t3_eu_valid", 64'(eu_valid_o), 64'd1);
        chk("t3_req_valid", 64'(rf_req_valid_o), 64'd0);
        chk_w("t3_op0", eu_operands_o[0], '0);
        chk_w("t3_op1", eu_operands_o[1], '0);
        chk("t3_tag", 64'(eu_tag_o), 64'd3);
        tick();
        chk("t3_nreq", 64'(nreq - base), 64'd0);
        handoff("t3");

        // RF not ready for 3 cycles, latency 4, EU stalls 5 cycles.
        lat = 4;
        base = nrsp;
        rf_req_ready_i = 1'b0;
        set_disp(3'd4, 2'b11, 6'd2, 6'd4);
        tick();
        disp_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_stall_valid", 64'(rf_req_valid_o), 64'd1);
            chk("t4_stall_reg", 64'(rf_req_reg_o), 64'd2);
            tick();
        end
        rf_req_ready_i = 1'b1;
        for (int i = 0; i < 30 && eu_valid_o !== 1'b1; i++) tick();
        chk("t4_eu_valid", 64'(eu_valid_o), 64'd1);
        chk("t4_nrsp", 64'(nrsp - base), 64'd2);
        chk_w("t4_op0", eu_operands_o[0], rfd(6'd2));
        chk_w("t4_op1", eu_operands_o[1], rfd(6'd4));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_valid", 64'(eu_valid_o), 64'd1);
            chk("t4_hold_tag", 64'(eu_tag_o), 64'd4);
            chk_w("t4_hold_op1", eu_operands_o[1], rfd(6'd4));
        end
        handoff("t4");
        lat = 1;

        // Tag 5 in READY, tag 6 offered during the hand-off.
        set_disp(3'd5, 2'b00, 6'd0, 6'd0);
        tick();
        chk("t5_eu_valid", 64'(eu_valid_o), 64'd1);
        chk("t5_tag5", 64'(eu_tag_o), 64'd5);
        set_disp(3'd6, 2'b00, 6'd0, 6'd0);
        eu_ready_i = 1'b1;
        #1;
`ifdef BGPU_OPC_BACK_TO_BACK_EN
        chk("t5_b2b_opc_ready", 64'(opc_ready_o), 64'd1);
        tick();
        disp_valid_i = 1'b0;
        chk("t5_b2b_eu_valid", 64'(eu_valid_o), 64'd1);
        chk("t5_b2b_tag6", 64'(eu_tag_o), 64'd6);
`else
        chk("t5_opc_ready_busy", 64'(opc_ready_o), 64'd0);
        tick();
        chk("t5_idle_valid", 64'(eu_valid_o), 64'd0);
        chk("t5_idle_opc_ready", 64'(opc_ready_o), 64'd1);
        tick();
        disp_valid_i = 1'b0;
        chk("t5_eu_valid6", 64'(eu_valid_o), 64'd1);
        chk("t5_tag6", 64'(eu_tag_o), 64'd6);
`endif
        handoff("t5");

        // Reset in COLLECT after one response, then a normal instruction.
        lat = 2;
        set_disp(3'd7, 2'b11, 6'd1, 6'd3);
        tick();
        disp_valid_i = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_collect_eu_valid", 64'(eu_valid_o), 64'd0);
        chk("t6_collect_req_valid", 64'(rf_req_valid_o), 64'd0);
        rst_n = 1'b0;
        #1;
        chk_reset("t6_rst");
        tick();
        rst_n = 1'b1;
        tick();
        lat = 1;
        set_disp(3'd2, 2'b11, 6'd3, 6'd7);
        tick();
        disp_valid_i = 1'b0;
        for (int i = 0; i < 20 && eu_valid_o !== 1'b1; i++) tick();
        chk("t6_eu_valid", 64'(eu_valid_o), 64'd1);
        chk("t6_tag", 64'(eu_tag_o), 64'd2);
        chk_w("t6_op0", eu_operands_o[0], rfd(6'd3));
        chk_w("t6_op1", eu_operands_o[1], rfd(6'd7));
        handoff("t6");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
